// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode encoding and widths shared by the fetch stage and its controller.
package fetch_unit_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: controller strobes, memory word and fetch-stage outputs.
interface fetch_unit_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
);
    import fetch_unit_pkg::*;

    logic [DWIDTH-1:0] data_in;
    logic              load_ir;
    logic              inc_pc;
    logic              load_pc;
    logic              halt;
    logic              fetch;
    opcode_t           opcode;
    logic [AWIDTH-1:0] ir_addr;
    logic [AWIDTH-1:0] pc_addr;
    logic [AWIDTH-1:0] addr;
    logic [CWIDTH-1:0] instr_cnt;
    logic              pc_wrap;

    modport master (
        output data_in, load_ir, inc_pc, load_pc, halt, fetch,
        input  opcode, ir_addr, pc_addr, addr, instr_cnt, pc_wrap
    );

    modport slave (
        input  data_in, load_ir, inc_pc, load_pc, halt, fetch,
        output opcode, ir_addr, pc_addr, addr, instr_cnt, pc_wrap
    );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: loadable program counter, load beats enable; wrap pulses on an all-ones increment.
module pc_counter #(
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              load,
    input  logic              enable,
    input  logic [AWIDTH-1:0] data,
    output logic [AWIDTH-1:0] count,
    output logic              wrap
);

    logic [AWIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            r_count <= '0;
        else if (load)
            r_count <= data;
        else if (enable)
            r_count <= r_count + AWIDTH'(1);
    end

    assign count = r_count;
    assign wrap  = enable && !load && (r_count == '1);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: VeriRISC fetch stage holding IR, PC and a saturating fetch counter.
// Define FETCH_WRAP_DETECT_EN to get a sticky PC-wrap flag; otherwise pc_wrap is tied low.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_,
    fetch_unit_if.slave    bus
);

    logic [DWIDTH-1:0] r_ir;
    logic [CWIDTH-1:0] r_cnt;
    logic [AWIDTH-1:0] w_ir_addr;
    logic [AWIDTH-1:0] w_pc;
    logic              w_run;
    logic              w_wrap;
    logic              w_unused;

    assign w_run     = !bus.halt;
    assign w_ir_addr = r_ir[AWIDTH-1:0];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_ir  <= '0;
            r_cnt <= '0;
        end else if (w_run && bus.load_ir) begin
            r_ir <= bus.data_in;
            if (r_cnt != '1)
                r_cnt <= r_cnt + CWIDTH'(1);
        end
    end

    // The PC loads the operand held before this edge's IR capture
    pc_counter #(.AWIDTH(AWIDTH)) u_pc (
        .clk    (clk),
        .rst_   (rst_),
        .load   (bus.load_pc && w_run),
        .enable (bus.inc_pc && w_run),
        .data   (w_ir_addr),
        .count  (w_pc),
        .wrap   (w_wrap)
    );

    assign bus.opcode    = opcode_t'(r_ir[DWIDTH-1 -: OPCODE_W]);
    assign bus.ir_addr   = w_ir_addr;
    assign bus.pc_addr   = w_pc;
    assign bus.addr      = bus.fetch ? w_pc : w_ir_addr;
    assign bus.instr_cnt = r_cnt;
    assign w_unused      = ^{r_ir, w_wrap};

`ifdef FETCH_WRAP_DETECT_EN
    logic r_pc_wrap;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            r_pc_wrap <= 1'b0;
        else if (w_wrap)
            r_pc_wrap <= 1'b1;
    end

    assign bus.pc_wrap = r_pc_wrap;
`else
    assign bus.pc_wrap = 1'b0;
`endif

endmodule
